// File: rtl/uart_rx_fifo.sv
// Receive-side buffer for the UART: unloads bytes from the holding register into a
// small FIFO and hands them to the consumer one registered byte per read request.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  rxclk,
    input  logic                  reset,
    input  logic                  rx_empty,
    input  logic [7:0]            rx_data,
    output logic                  uld_rx_data,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        UNLD,
        CAPT
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    next_uld;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [7:0]              mem [DEPTH];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign rd_fire    = rd_en && !fifo_empty && !flush;

    // Only IDLE looks at rx_empty, so a byte is never unloaded twice; the full check
    // there guarantees space at CAPT because nothing else can add bytes meanwhile.
    always_comb begin
        next_state = state;
        next_uld   = 1'b0;
        wr_fire    = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty && !fifo_full) begin
                        next_state = UNLD;
                        next_uld   = 1'b1;
                    end
                end
                UNLD: next_state = CAPT;
                CAPT: begin
                    wr_fire    = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            uld_rx_data <= 1'b0;
        end else begin
            state       <= next_state;
            uld_rx_data <= next_uld;
        end
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A read in the CAPT cycle sees the old memory contents, never the byte being written.
    always_ff @(posedge rxclk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    a_uld_single_cycle: assert property (@(posedge rxclk) disable iff (!reset)
        uld_rx_data |=> !uld_rx_data);

    a_capt_has_room: assert property (@(posedge rxclk) disable iff (!reset)
        (state == CAPT) |-> !fifo_full);

    a_count_in_range: assert property (@(posedge rxclk) disable iff (!reset)
        count <= FULL_COUNT);

endmodule
